// File: rtl/aes_dec_iter.sv
// aes_dec_iter: iterative AES-128 decryption core, one inverse round per clock.
// Accept -> 10 forward key-schedule cycles -> 10 inverse rounds -> hold result.
// Optional build macro AES_DEC_KEYCACHE_EN keeps the last key and its rk10 so a
// repeated key skips the forward schedule.
module aes_dec_iter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] datain,
  input  logic [127:0] key,
  output logic [127:0] finalout,
  output logic         out_valid,
  input  logic         out_ready
);

  typedef enum logic [1:0] {ST_IDLE, ST_KEXP, ST_ROUND, ST_DONE} state_t;

  state_t       r_state;
  logic [3:0]   r_cnt;
  logic [127:0] r_s;
  logic [127:0] r_key;
  logic [127:0] r_out;
  logic         r_out_valid;
  logic         r_in_ready;
`ifdef AES_DEC_KEYCACHE_EN
  logic [127:0] r_ckey;
  logic [127:0] r_crk10;
  logic         r_cvalid;
`endif

  logic [3:0]   w_rc_idx;
  logic [7:0]   w_rcon;
  logic [127:0] w_kfwd;
  logic [127:0] w_kinv;
  logic [127:0] w_round;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Inverse as a^254 (square-and-multiply); maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] v;
    v = ginv(a);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] b);
    return ginv({b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] subrot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] key_fwd(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = rk[127:96] ^ subrot(rk[31:0]) ^ {rc, 24'h0};
    n1 = rk[95:64] ^ n0;
    n2 = rk[63:32] ^ n1;
    n3 = rk[31:0]  ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] key_inv(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] p0, p1, p2, p3;
    p3 = rk[31:0]  ^ rk[63:32];
    p2 = rk[63:32] ^ rk[95:64];
    p1 = rk[95:64] ^ rk[127:96];
    p0 = rk[127:96] ^ subrot(p3) ^ {rc, 24'h0};
    return {p0, p1, p2, p3};
  endfunction

  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic mix);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [127:0] o;
    for (int unsigned i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
    for (int unsigned r = 0; r < 4; r++)
      for (int unsigned c = 0; c < 4; c++)
        t[r+4*c] = isbox(b[r + 4*((c + 4 - r) % 4)]) ^ rk[127-8*(r+4*c) -: 8];
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      if (mix) begin
        o[127-8*(4*c)   -: 8] = gmul(t[4*c], 8'h0e) ^ gmul(t[4*c+1], 8'h0b) ^ gmul(t[4*c+2], 8'h0d) ^ gmul(t[4*c+3], 8'h09);
        o[127-8*(4*c+1) -: 8] = gmul(t[4*c], 8'h09) ^ gmul(t[4*c+1], 8'h0e) ^ gmul(t[4*c+2], 8'h0b) ^ gmul(t[4*c+3], 8'h0d);
        o[127-8*(4*c+2) -: 8] = gmul(t[4*c], 8'h0d) ^ gmul(t[4*c+1], 8'h09) ^ gmul(t[4*c+2], 8'h0e) ^ gmul(t[4*c+3], 8'h0b);
        o[127-8*(4*c+3) -: 8] = gmul(t[4*c], 8'h0b) ^ gmul(t[4*c+1], 8'h0d) ^ gmul(t[4*c+2], 8'h09) ^ gmul(t[4*c+3], 8'h0e);
      end else begin
        for (int unsigned r = 0; r < 4; r++) o[127-8*(4*c+r) -: 8] = t[4*c+r];
      end
    end
    return o;
  endfunction

  // KEXP walks Rcon_1..10 with the counter; ROUND undoes step counter+1 to get rk_counter.
  assign w_rc_idx = (r_state == ST_ROUND) ? r_cnt + 4'd1 : r_cnt;
  assign w_rcon   = rcon(w_rc_idx);
  assign w_kfwd   = key_fwd(r_key, w_rcon);
  assign w_kinv   = key_inv(r_key, w_rcon);
  assign w_round  = inv_round(r_s, w_kinv, r_cnt != 4'd0);

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign finalout  = r_out;

  // Control FSM plus state/key datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_s         <= '0;
      r_key       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
`ifdef AES_DEC_KEYCACHE_EN
      r_ckey      <= '0;
      r_crk10     <= '0;
      r_cvalid    <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_s        <= datain;
            r_state    <= ST_KEXP;
            r_in_ready <= 1'b0;
`ifdef AES_DEC_KEYCACHE_EN
            // Counter 0 in KEXP marks a cache hit: r_key already holds rk10.
            if (r_cvalid && (key == r_ckey)) begin
              r_key <= r_crk10;
              r_cnt <= '0;
            end else begin
              r_key    <= key;
              r_cnt    <= 4'd1;
              r_ckey   <= key;
              r_cvalid <= 1'b0;
            end
`else
            r_key <= key;
            r_cnt <= 4'd1;
`endif
          end
        end
        ST_KEXP: begin
`ifdef AES_DEC_KEYCACHE_EN
          if (r_cnt == 4'd0) begin
            r_s     <= r_s ^ r_key;
            r_cnt   <= 4'd9;
            r_state <= ST_ROUND;
          end else
`endif
          begin
            r_key <= w_kfwd;
            if (r_cnt == 4'd10) begin
              r_s     <= r_s ^ w_kfwd;
              r_cnt   <= 4'd9;
              r_state <= ST_ROUND;
`ifdef AES_DEC_KEYCACHE_EN
              r_crk10  <= w_kfwd;
              r_cvalid <= 1'b1;
`endif
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        ST_ROUND: begin
          r_s   <= w_round;
          r_key <= w_kinv;
          if (r_cnt == 4'd0) begin
            r_out       <= w_round;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/aes_dec_iter.md
# aes_dec_iter

Iterative AES-128 decryption core: the inverse counterpart of the pipelined `AES_TOP` encryptor. It accepts one 128-bit ciphertext and key per transaction over a valid/ready handshake, derives the round-10 key on the fly, and runs ten inverse rounds, one per clock. Its output is the FIPS-197 plaintext. It sits on the receive side of the crypto datapath, behind the encryptor's consumer.

## Interface
- No parameters. Key size is fixed at 128 bits; Nr is fixed at 10.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `datain`/`key` are valid.
- `in_ready`  out  1  core can accept; high only in IDLE.
- `datain`  in  128  ciphertext; `[127:120]` is byte 0 (column-major, FIPS-197 order).
- `key`  in  128  cipher key, same byte order.
- `finalout`  out  128  plaintext, registered.
- `out_valid`  out  1  `finalout` is valid.
- `out_ready`  in  1  downstream accepts `finalout`.

## Operation
- States: IDLE, KEXP, ROUND, DONE. All state is cleared by `rst_n` low.
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `finalout`=0, round counter 0, state/key registers 0.
- IDLE:
  - On `in_valid & in_ready`, capture `datain` into the state register and `key` into the key register.
  - Load counter=1 and go to KEXP.
- KEXP runs 10 cycles, counter 1..10:
  - Each cycle applies the forward key schedule, `rk_i = f(rk_{i-1}, Rcon_i)`.
  - On the counter=10 edge, the key register gets rk10 and the state gets `ct ^ rk10`.
  - Go to ROUND with counter=9.
- ROUND runs 10 cycles, counter 9..0:
  - Each cycle: `s = InvSubBytes(InvShiftRows(s)) ^ rk_counter`, then `InvMixColumns` if counter≠0.
  - The key register steps backward through the inverse schedule: `rk_{r} = finv(rk_{r+1}, Rcon_{r+1})`, where `w[j] ^= w[j-1]` for j=3..1 and `w0 ^= SubWord(RotWord(w3')) ^ Rcon`.
  - On the counter=0 edge, `finalout` gets the result, `out_valid` goes to 1, and the state goes to DONE.
- DONE:
  - Hold `finalout` and `out_valid` stable until `out_ready`.
  - On `out_valid & out_ready`, `out_valid` goes to 0 and the state goes to IDLE.
  - `finalout` keeps its value after the handshake.
- S-box and inverse S-box: combinational, as a GF(2^8) inverse (poly 0x11B) plus the affine / inverse affine maps. No 256-entry tables.
- Rcon sequence: 01,02,04,08,10,20,40,80,1B,36.
- Inputs are ignored outside IDLE. `out_ready` is ignored outside DONE.
- Reset mid-operation aborts the block: no output, IDLE on release.

## Timing
- Accept edge is E0. `out_valid` rises after edge E20, giving 20-cycle latency.
- `in_ready` rises again one cycle after the output handshake edge.
- Minimum period is 22 cycles per block with `out_ready` tied high.
- `in_ready` is a pure decode of state. It has no combinational path from `in_valid` or `out_ready`.
- Critical path: InvShiftRows → inverse S-box → XOR → InvMixColumns, in parallel with the inverse key step (one S-box layer).

## Configuration
- `AES_DEC_KEYCACHE_EN` defined:
  - Adds a 128-bit cached key, a 128-bit cached rk10, and a cache-valid flag. All reset to 0.
  - The flag is set when KEXP completes.
  - On accept, if the flag is set and `key` equals the cached key, skip KEXP. The next edge loads rk10 from the cache, sets state `ct ^ rk10`, and enters ROUND. Latency becomes 11.
  - Reset clears the flag.
- `AES_DEC_KEYCACHE_EN` undefined: no cache registers; every block runs KEXP (latency 20).

## Test plan
- Key `2b7e151628aed2a6abf7158809cf4f3c`, ct `3925841d02dc09fbdc118597196a0b32` → `finalout` `3243f6a8885a308d313198a2e0370734`, `out_valid` exactly 20 cycles after accept.
- Key `000102030405060708090a0b0c0d0e0f`, ct `69c4e0d86a7b0430d8cdb78070b4c55a` → `00112233445566778899aabbccddeeff`.
- Key 0, ct `66e94bd4ef8a2c3b884cfa59ca342b2e` → 0.
- Hold `out_ready`=0 for 7 cycles after `out_valid` → `finalout` stable, `in_ready`=0 throughout. Then `out_ready`=1 → `out_valid` falls next edge, `in_ready`=1.
- Pulse `rst_n` low at cycle 12 of a block → all outputs return to reset values immediately. A fresh block after release decrypts correctly.
- With `AES_DEC_KEYCACHE_EN`: two back-to-back blocks with key `000102…0f` → first block latency 20, second block latency 11, both correct. Then change the key → latency 20 again.
